// File: rtl/speed_ctrl_if.sv
// Button inputs and speed/run outputs of the speed control stage.
interface speed_ctrl_if;
  logic        btn_faster;
  logic        btn_slower;
  logic        btn_pause;
  logic        btn_step;
  logic [31:0] freq;
  logic [2:0]  level;
  logic        run;
  logic        step_pulse;

  // Board side: drives raw buttons, consumes tick word and run/step controls.
  modport master (
    output btn_faster, btn_slower, btn_pause, btn_step,
    input  freq, level, run, step_pulse
  );

  // Speed control stage itself.
  modport slave (
    input  btn_faster, btn_slower, btn_pause, btn_step,
    output freq, level, run, step_pulse
  );
endinterface

// File: rtl/speed_ctrl.sv
// Speed control front end: debounces four buttons, keeps a saturating speed
// level, derives the tick half-period word and runs the run/pause/step FSM.
module speed_ctrl #(
  parameter int unsigned BASE_FREQ       = 50_000_000,
  parameter int unsigned MAX_LEVEL       = 7,
  parameter int unsigned DEFAULT_LEVEL   = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input logic         clk,
  input logic         rst,
  speed_ctrl_if.slave bus
);

  localparam int unsigned NumBtn    = 4;
  localparam int unsigned BtnFaster = 0;
  localparam int unsigned BtnSlower = 1;
  localparam int unsigned BtnPause  = 2;
  localparam int unsigned BtnStep   = 3;
  // Counter only needs to reach DEBOUNCE_CYCLES-1; the next mismatch accepts.
  localparam int unsigned CntW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast      = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]      LevelMax     = 3'(MAX_LEVEL);
  localparam logic [2:0]      LevelDefault = 3'(DEFAULT_LEVEL);
  localparam logic [31:0]     FreqDefault  = 32'(BASE_FREQ >> DEFAULT_LEVEL);

  typedef enum logic [0:0] {StRun, StPause} state_e;

  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1_q, sync2_q;
  logic [NumBtn-1:0] stable_q, stable_d, stable_dly_q;
  logic [NumBtn-1:0] press_q, press_d;
  logic [CntW-1:0]   cnt_q [NumBtn];
  logic [CntW-1:0]   cnt_d [NumBtn];

  logic [2:0]  level_q, level_d;
  logic [31:0] freq_q, freq_d;
  state_e      state_q, state_d;
  logic        run_q, run_d;
  logic        step_q, step_d;

  assign btn_raw = {bus.btn_step, bus.btn_pause, bus.btn_slower, bus.btn_faster};

  // Debounce: count consecutive mismatches, accept the synced value after enough of them.
  always_comb begin
    for (int i = 0; i < NumBtn; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
    // Rising edge of the debounced level only; releases are silent.
    press_d = stable_q & ~stable_dly_q;
  end

  // Synchronizers, debounce state and press pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      press_q      <= '0;
      for (int i = 0; i < NumBtn; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= press_d;
      for (int i = 0; i < NumBtn; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Saturating speed level; freq tracks the level one edge later.
  always_comb begin
    level_d = level_q;
    case ({press_q[BtnSlower], press_q[BtnFaster]})
      2'b01:   if (level_q != LevelMax) level_d = level_q + 3'd1;
      2'b10:   if (level_q != 3'd0)     level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
    freq_d = 32'(BASE_FREQ) >> level_q;
  end

  // Speed level and tick word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= LevelDefault;
      freq_q  <= FreqDefault;
    end else begin
      level_q <= level_d;
      freq_q  <= freq_d;
    end
  end

  // Run/pause next state; pause wins over step in the same cycle.
  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    case (state_q)
      StRun: begin
        if (press_q[BtnPause]) state_d = StPause;
      end
      StPause: begin
        if (press_q[BtnPause]) begin
          state_d = StRun;
        end else if (press_q[BtnStep]) begin
          step_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
    run_d = (state_d == StRun);
  end

  // Run/pause FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      run_q   <= 1'b1;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      step_q  <= step_d;
    end
  end

  assign bus.freq       = freq_q;
  assign bus.level      = level_q;
  assign bus.run        = run_q;
  assign bus.step_pulse = step_q;

endmodule
